sar_adc_decimator: RTL and testbench

//  Digital back-end stage directly downstream of the SAR-ADC top. Captures each

---
 rtl/sar_adc_decimator.sv | 113 +++++++++++
 tb/tb_sar_adc_decimator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_decimator.sv
// SAR-ADC back end: edge-detects the ready flag, block-averages 2**LOG2_DEC
// conversion words and hands the result out on a valid/ack port with overrun flag.
module sar_adc_decimator #(
    parameter int unsigned N_BIT     = 10,
    parameter int unsigned LOG2_DEC  = 2,
    parameter int unsigned TWOS_COMP = 0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [N_BIT-1:0] adc_dout,
    input  logic             adc_ready,
    input  logic             out_ack,
    input  logic             clr_ovr,
    output logic [N_BIT-1:0] out_data,
    output logic             out_valid,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned AW  = N_BIT + LOG2_DEC;
    localparam int unsigned CW  = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam int unsigned DEC = 1 << LOG2_DEC;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEC - 1);
    localparam logic [N_BIT-1:0] MSB_FLIP =
        (TWOS_COMP != 0) ? {1'b1, {(N_BIT-1){1'b0}}} : '0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic             ready_d;
    logic             stb;
    logic             dump;
    logic [AW-1:0]    acc_q, acc_d, sum;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_BIT-1:0] result;

    assign stb    = adc_ready & ~ready_d;
    assign sum    = acc_q + AW'(adc_dout);
    // offset-binary to two's complement is just an MSB flip
    assign result = N_BIT'(sum >> LOG2_DEC) ^ MSB_FLIP;
    assign busy   = (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dump    = 1'b0;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (stb) begin
                    if (cnt_q == CNT_LAST) begin
                        dump  = 1'b1;
                        acc_d = '0;
                        cnt_d = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            ready_d <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_d <= adc_ready;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (dump) begin
                out_data  <= result;
                out_valid <= 1'b1;
            end else if (out_ack) begin
                out_valid <= 1'b0;
            end
            // a set in the same cycle takes priority over clr_ovr
            if (dump && out_valid && !out_ack)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_adc_decimator.sv
// Directed bench for sar_adc_decimator: averaging, strobe detect, handshake,
// overrun, en flush, async reset, and two's-complement pass-through.
module tb_sar_adc_decimator;

    logic       clk = 1'b0;
    logic       rstb, en, adc_ready, out_ack, clr_ovr;
    logic [9:0] adc_dout;
    logic [9:0] out_data;
    logic       out_valid, overrun, busy;

    logic       adc_ready2;
    logic [9:0] adc_dout2;
    logic [9:0] out_data2;
    logic       out_valid2, overrun2, busy2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    sar_adc_decimator #(.N_BIT(10), .LOG2_DEC(2), .TWOS_COMP(0)) dut (
        .clk(clk), .rstb(rstb), .en(en), .adc_dout(adc_dout),
        .adc_ready(adc_ready), .out_ack(out_ack), .clr_ovr(clr_ovr),
        .out_data(out_data), .out_valid(out_valid), .overrun(overrun), .busy(busy)
    );

    sar_adc_decimator #(.N_BIT(10), .LOG2_DEC(0), .TWOS_COMP(1)) dut_tc (
        .clk(clk), .rstb(rstb), .en(en), .adc_dout(adc_dout2),
        .adc_ready(adc_ready2), .out_ack(out_ack), .clr_ovr(clr_ovr),
        .out_data(out_data2), .out_valid(out_valid2), .overrun(overrun2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [9:0] w);
        adc_dout  = w;
        adc_ready = 1'b1;
        tick();
        adc_ready = 1'b0;
        tick();
    endtask

    task automatic strobe2(input logic [9:0] w);
        adc_dout2  = w;
        adc_ready2 = 1'b1;
        tick();
        adc_ready2 = 1'b0;
        tick();
    endtask

    task automatic ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    initial begin
        rstb = 1'b0; en = 1'b0; adc_ready = 1'b0; out_ack = 1'b0; clr_ovr = 1'b0;
        adc_dout = '0; adc_ready2 = 1'b0; adc_dout2 = '0;
        repeat (2) tick();
        chk("rst_data",  out_data,  0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ovr",   overrun,   0);
        chk("rst_busy",  busy,      0);
        rstb = 1'b1;
        en   = 1'b1;
        tick();

        // basic block average with one-cycle latency
        strobe(10'd100);
        chk("t1_busy1", busy, 1);
        strobe(10'd101);
        strobe(10'd102);
        chk("t1_pre_valid", out_valid, 0);
        adc_dout = 10'd103; adc_ready = 1'b1;
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_data",  out_data,  101);
        chk("t1_busy0", busy,      0);
        adc_ready = 1'b0;
        tick();
        ack();
        chk("t1_acked", out_valid, 0);
        ack();
        chk("ack_idle_valid", out_valid, 0);

        // truncation and full-scale sum
        strobe(10'd1); strobe(10'd2); strobe(10'd2); strobe(10'd2);
        chk("trunc_data", out_data, 1);
        ack();
        repeat (4) strobe(10'd1023);
        chk("max_data", out_data, 1023);
        ack();

        // ready held high is a single strobe
        adc_dout = 10'd50; adc_ready = 1'b1;
        repeat (20) tick();
        adc_ready = 1'b0;
        tick();
        chk("t2_busy",  busy,      1);
        chk("t2_valid", out_valid, 0);
        en = 1'b0; tick();
        chk("t2_flush_busy", busy, 0);
        en = 1'b1; tick();

        // overwrite without ack sets overrun
        repeat (4) strobe(10'd100);
        chk("t3_first_valid", out_valid, 1);
        chk("t3_first_ovr",   overrun,   0);
        repeat (4) strobe(10'd200);
        chk("t3_data", out_data, 200);
        chk("t3_ovr",  overrun,  1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("t3_clr_ovr",   overrun,   0);
        chk("t3_clr_valid", out_valid, 1);

        // ack coincident with new result
        repeat (3) strobe(10'd40);
        adc_dout = 10'd40; adc_ready = 1'b1; out_ack = 1'b1;
        tick();
        out_ack = 1'b0; adc_ready = 1'b0;
        tick();
        chk("t4_valid", out_valid, 1);
        chk("t4_data",  out_data,  40);
        chk("t4_ovr",   overrun,   0);
        ack();
        chk("t4_acked", out_valid, 0);

        // overrun set beats clr_ovr in the same cycle
        repeat (4) strobe(10'd8);
        repeat (3) strobe(10'd16);
        adc_dout = 10'd16; adc_ready = 1'b1; clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0; adc_ready = 1'b0;
        tick();
        chk("setwin_ovr",  overrun,  1);
        chk("setwin_data", out_data, 16);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("setwin_clr", overrun, 0);
        ack();

        // en drop discards the partial block
        strobe(10'd500); strobe(10'd500);
        en = 1'b0; tick();
        en = 1'b1; tick();
        repeat (4) strobe(10'd8);
        chk("t5_data",  out_data,  8);
        chk("t5_valid", out_valid, 1);
        strobe(10'd300); strobe(10'd300);
        chk("t5_busy_pre", busy, 1);
        #2;
        rstb = 1'b0;
        #1;
        chk("t5_rst_data",  out_data,  0);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ovr",   overrun,   0);
        chk("t5_rst_busy",  busy,      0);
        tick();
        rstb = 1'b1;
        tick();

        // two's-complement pass-through instance
        strobe2(10'd512);
        chk("t6_512",  out_data2, 10'h000);
        chk("t6_valid", out_valid2, 1);
        strobe2(10'd0);
        chk("t6_0",    out_data2, 10'h200);
        strobe2(10'd1023);
        chk("t6_1023", out_data2, 10'h1FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
